// File: rtl/rr_arbiter_hs.sv
// rr_arbiter_hs
//   N-way round-robin arbiter with a registered grant and a valid/ready
//   handshake toward one shared resource. A grant, once issued, is held
//   stable until the consumer accepts it. On acceptance the arbiter
//   re-arbitrates in the same cycle, so ready held high gives one grant
//   per cycle.
//
//   Optional feature macro: ARB_LOCK_EN (adds input 'lock'; a handshake
//   with lock=1 keeps priority on the current winner, for multi-beat bursts).
//
// Ports
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   req         in   N    request vector, bit i = requester i
//   gnt_valid   out  1    a grant is outstanding
//   gnt_id      out  IDW  index of granted requester (valid with gnt_valid)
//   gnt_onehot  out  N    one-hot of gnt_id while gnt_valid, else zero
//   gnt_ready   in   1    consumer accepts the current grant this cycle
//   lock        in   1    (ARB_LOCK_EN only) hold priority on the winner
module rr_arbiter_hs #(
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   gnt_onehot,
  input  logic           gnt_ready
`ifdef ARB_LOCK_EN
  ,
  input  logic           lock
`endif
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [IDW-1:0] LAST = IDW'(N - 1);
  localparam logic [IDW:0]   N_W  = (IDW + 1)'(N);

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] id_reg, id_next;

  logic           hs;
  logic           any_req;
  logic           lock_eff;
  logic [IDW-1:0] w_inc;
  logic [IDW-1:0] start;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [IDW-1:0][N-1:0] off_terms;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;
  logic [IDW-1:0] pick;

`ifdef ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  assign any_req = |req;
  assign hs      = (state_reg == GRANT) && gnt_ready;
  assign w_inc   = (id_reg == LAST) ? '0 : id_reg + 1'b1;

  // Priority start: the pointer when leaving IDLE; on a handshake the
  // successor of the winner (or the winner itself when locked).
  always_comb begin
    start = ptr_reg;
    if (state_reg == GRANT) begin
      start = lock_eff ? id_reg : w_inc;
    end
  end

  // Rotate req so that bit 0 is the highest-priority requester, find the
  // first set bit, then map the offset back to an absolute index.
  assign rot = N'({req, req} >> start);

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_first
      localparam logic [N-1:0] BELOW = N'((1 << gi) - 1);
      assign first[gi] = rot[gi] & ~|(rot & BELOW);
    end
    // One-hot to binary: offset bit gi is the OR of the one-hot bits whose
    // index has bit gi set.
    for (gi = 0; gi < IDW; gi++) begin : g_enc
      for (gj = 0; gj < N; gj++) begin : g_term
        if (((gj >> gi) & 1) == 1) begin : g_on
          assign off_terms[gi][gj] = first[gj];
        end else begin : g_off
          assign off_terms[gi][gj] = 1'b0;
        end
      end
      assign off[gi] = |off_terms[gi];
    end
  endgenerate

  assign sum  = {1'b0, start} + {1'b0, off};
  assign pick = (sum >= N_W) ? IDW'(sum - N_W) : IDW'(sum);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = GRANT;
          id_next    = pick;
        end
      end
      GRANT: begin
        if (hs) begin
          if (!lock_eff) ptr_next = w_inc;
          if (any_req) begin
            id_next = pick;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gnt_valid = (state_reg == GRANT);
    gnt_id    = id_reg;
  end

  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign gnt_onehot[gi] = gnt_valid && (id_reg == IDW'(gi));
    end
  endgenerate

endmodule
